pulse_launch: RTL and testbench

Sending end of the cross-domain strobe path: converts single-cycle event pulses in the local `clk` domain into a four-phase level request (`req_out`) for a receiver in another clock domain. That receiver captures the rising edge of `req_out` with its own async edge-capture synchronizer and echoes an acknowledge level back. The block synchronizes the returning `ack_async`, enforces minimum high and low times, queues events that arrive while a transfer is in flight, and recovers from a receiver that never acknowledges.

---
 rtl/pulse_launch_pkg.sv | 10 +
 rtl/sync_2ff.sv | 24 ++
 rtl/pulse_launch.sv | 116 +++++++++++
 tb/tb_pulse_launch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pulse_launch_pkg.sv
// rtl/pulse_launch_pkg.sv - shared types for the cross-domain pulse launcher
package pulse_launch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } launch_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop level synchronizer with async active-low clear
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pulse_launch.sv
// rtl/pulse_launch.sv - turns local event pulses into a four-phase request level
module pulse_launch
  import pulse_launch_pkg::*;
#(
  parameter int MIN_HIGH    = 4,
  parameter int ACK_TIMEOUT = 1023,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pulse_in,
  input  logic              ack_async,
  output logic              req_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              timeout
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0]  TMO_CNT  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  launch_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              req_q, busy_q;
  logic              timeout_q, timeout_d;
  logic              ack_sync;
  logic              launch, pend_inc, pend_dec;

  sync_2ff u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ack_async),
    .q_o   (ack_sync)
  );

  // A launch with an empty queue consumes pulse_in directly; otherwise the queue feeds it.
  assign launch   = (state_q == IDLE) && (pulse_in || (pend_q != '0)) && !ack_sync;
  assign pend_dec = launch && (pend_q != '0);
  assign pend_inc = pulse_in && !(launch && (pend_q == '0));
  assign overflow = pend_inc && !pend_dec && (pend_q == PEND_MAX);

  always_comb begin
    pend_d = pend_q;
    if (pend_inc && !pend_dec && (pend_q != PEND_MAX)) begin
      pend_d = pend_q + 1'b1;
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (ack_sync && (cnt_q >= MIN_CNT)) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_CNT) begin
          state_d   = RELEASE;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        // Count saturates at the minimum; a stuck-high ack simply parks us here.
        if (!ack_sync && (cnt_q >= MIN_CNT)) begin
          state_d = IDLE;
        end else if (cnt_q < MIN_CNT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      req_q     <= (state_d == HOLD);
      busy_q    <= (state_d != IDLE);
      timeout_q <= timeout_d;
    end
  end

  assign req_out = req_q;
  assign busy    = busy_q;
  assign pending = pend_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_pulse_launch.sv
// tb/tb_pulse_launch.sv - scoreboard bench for pulse_launch
module tb_pulse_launch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse_in;
  logic       ack_drv;
  logic       rx_en;
  logic       rx_q = 1'b0;
  logic       ack_async;
  logic       req_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;
  logic       timeout;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   rises = 0;
  logic req_prev = 1'b0;

  typedef struct {
    int         cyc;
    logic       req;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
    logic       tmo;
    string      name;
  } exp_t;

  exp_t sb[$];

  pulse_launch #(
    .MIN_HIGH    (4),
    .ACK_TIMEOUT (16),
    .PEND_W      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .ack_async (ack_async),
    .req_out   (req_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Far-domain receiver: echoes req_out one cycle later when enabled.
  always @(posedge clk) rx_q <= req_out;
  assign ack_async = rx_en ? rx_q : ack_drv;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(int c, logic r, logic b, logic [1:0] p, logic o, logic t, string n);
    exp_t e;
    e.cyc = c; e.req = r; e.busy = b; e.pend = p; e.ovf = o; e.tmo = t; e.name = n;
    sb.push_back(e);
  endtask

  task automatic at(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (req_out && !req_prev) rises++;
    req_prev = req_out;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        chk({e.name, ".missed"}, cyc, e.cyc);
      end else begin
        chk({e.name, ".req"},      req_out,  e.req);
        chk({e.name, ".busy"},     busy,     e.busy);
        chk({e.name, ".pending"},  pending,  e.pend);
        chk({e.name, ".overflow"}, overflow, e.ovf);
        chk({e.name, ".timeout"},  timeout,  e.tmo);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, got %0d cycles expected under 2000", cyc);
    $fatal(1);
  end

  initial begin
    int b;
    int r0;
    rst_n = 1'b0; pulse_in = 1'b0; ack_drv = 1'b0; rx_en = 1'b0;
    #2;
    chk("reset.req", req_out, 0);
    chk("reset.busy", busy, 0);
    chk("reset.pending", pending, 0);
    chk("reset.overflow", overflow, 0);
    chk("reset.timeout", timeout, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    at(cyc + 2);

    b = cyc;
    push_exp(b+0,  0, 0, 0, 0, 0, "single.c0");
    push_exp(b+1,  1, 1, 0, 0, 0, "single.c1");
    push_exp(b+4,  1, 1, 0, 0, 0, "single.c4");
    push_exp(b+5,  0, 1, 0, 0, 0, "single.c5");
    push_exp(b+10, 0, 1, 0, 0, 0, "single.c10");
    push_exp(b+11, 0, 0, 0, 0, 0, "single.c11");
    pulse_in = 1'b1;
    at(b+1); pulse_in = 1'b0;
    at(b+2); ack_drv = 1'b1;
    at(b+8); ack_drv = 1'b0;
    at(b+13);

    b = cyc;
    push_exp(b+0,  0, 0, 0, 0, 0, "noack.c0");
    push_exp(b+1,  1, 1, 0, 0, 0, "noack.c1");
    push_exp(b+16, 1, 1, 0, 0, 0, "noack.c16");
    push_exp(b+17, 0, 1, 0, 0, 1, "noack.c17");
    push_exp(b+18, 0, 1, 0, 0, 0, "noack.c18");
    push_exp(b+20, 0, 1, 0, 0, 0, "noack.c20");
    push_exp(b+21, 0, 0, 0, 0, 0, "noack.c21");
    pulse_in = 1'b1;
    at(b+1); pulse_in = 1'b0;
    at(b+23);

    b = cyc;
    push_exp(b+0,  0, 0, 0, 0, 0, "burst.c0");
    push_exp(b+1,  1, 1, 0, 0, 0, "burst.c1");
    push_exp(b+2,  1, 1, 1, 0, 0, "burst.c2");
    push_exp(b+3,  1, 1, 2, 0, 0, "burst.c3");
    push_exp(b+4,  1, 1, 3, 1, 0, "burst.c4");
    push_exp(b+5,  0, 1, 3, 1, 0, "burst.c5");
    push_exp(b+6,  0, 1, 3, 0, 0, "burst.c6");
    push_exp(b+9,  0, 0, 3, 0, 0, "burst.c9");
    push_exp(b+10, 1, 1, 2, 0, 0, "burst.c10");
    push_exp(b+18, 0, 0, 2, 0, 0, "burst.c18");
    push_exp(b+19, 1, 1, 1, 0, 0, "burst.c19");
    push_exp(b+27, 0, 0, 1, 0, 0, "burst.c27");
    push_exp(b+28, 1, 1, 0, 0, 0, "burst.c28");
    push_exp(b+36, 0, 0, 0, 0, 0, "burst.c36");
    push_exp(b+40, 0, 0, 0, 0, 0, "burst.c40");
    rx_en = 1'b1;
    pulse_in = 1'b1;
    at(b+6); pulse_in = 1'b0;
    r0 = rises;
    at(b+41);
    chk("burst.rising_edges", rises - r0, 3);

    b = cyc;
    push_exp(b+0,  0, 0, 0, 0, 0, "simul.c0");
    push_exp(b+2,  0, 0, 0, 0, 0, "simul.c2");
    push_exp(b+3,  0, 0, 1, 0, 0, "simul.c3");
    push_exp(b+4,  0, 0, 2, 0, 0, "simul.c4");
    push_exp(b+5,  0, 0, 2, 0, 0, "simul.c5");
    push_exp(b+6,  0, 0, 2, 0, 0, "simul.c6");
    push_exp(b+7,  1, 1, 2, 0, 0, "simul.c7");
    push_exp(b+16, 1, 1, 1, 0, 0, "simul.c16");
    push_exp(b+25, 1, 1, 0, 0, 0, "simul.c25");
    push_exp(b+33, 0, 0, 0, 0, 0, "simul.c33");
    rx_en = 1'b0;
    ack_drv = 1'b1;
    at(b+2); pulse_in = 1'b1;
    at(b+4); pulse_in = 1'b0; ack_drv = 1'b0;
    at(b+6); pulse_in = 1'b1; rx_en = 1'b1;
    at(b+7); pulse_in = 1'b0;
    at(b+35);

    b = cyc;
    push_exp(b+0,  0, 0, 0, 0, 0, "rsthold.c0");
    push_exp(b+1,  1, 1, 0, 0, 0, "rsthold.c1");
    push_exp(b+2,  1, 1, 1, 0, 0, "rsthold.c2");
    push_exp(b+3,  0, 0, 0, 0, 0, "rsthold.c3");
    push_exp(b+5,  0, 0, 0, 0, 0, "rsthold.c5");
    push_exp(b+7,  0, 0, 0, 0, 0, "rsthold.c7");
    push_exp(b+8,  0, 0, 1, 0, 0, "rsthold.c8");
    push_exp(b+10, 0, 0, 1, 0, 0, "rsthold.c10");
    push_exp(b+11, 0, 0, 1, 0, 0, "rsthold.c11");
    push_exp(b+12, 1, 1, 0, 0, 0, "rsthold.c12");
    push_exp(b+19, 0, 1, 0, 0, 0, "rsthold.c19");
    push_exp(b+20, 0, 0, 0, 0, 0, "rsthold.c20");
    rx_en = 1'b0; ack_drv = 1'b0;
    pulse_in = 1'b1;
    at(b+2); ack_drv = 1'b1;
    at(b+3); pulse_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rsthold.async.req", req_out, 0);
    chk("rsthold.async.busy", busy, 0);
    chk("rsthold.async.pending", pending, 0);
    chk("rsthold.async.timeout", timeout, 0);
    at(b+5); rst_n = 1'b1;
    at(b+7); pulse_in = 1'b1;
    at(b+8); pulse_in = 1'b0;
    at(b+9); ack_drv = 1'b0;
    at(b+11); rx_en = 1'b1;
    at(b+22);

    at(cyc + 3);
    chk("scoreboard.drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
